// File: rtl/cnn_frame_ctrl.sv
// cnn_frame_ctrl: fetches one image frame from memory into the line-buffer pixel
// stream and writes pooled results back through a small result FIFO.
`default_nettype none

module cnn_frame_ctrl #(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] in_base_i,
    input  logic [ADDR_WIDTH-1:0] out_base_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ovf_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  pix_valid_o,
    output logic [DATA_WIDTH-1:0] pix_data_o,
    input  logic                  res_valid_i,
    input  logic [DATA_WIDTH-1:0] res_data_i
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int NRES = ((IMG_W - 2) / 2) * ((IMG_H - 2) / 2);
    localparam int PCW  = $clog2(NPIX + 1);
    localparam int FAW  = $clog2(OFIFO_DEPTH);
    localparam int FCW  = FAW + 1;

    localparam logic [PCW-1:0]        c_NPIX   = PCW'(NPIX);
    localparam logic [FCW-1:0]        c_FDEPTH = FCW'(OFIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_NRES   = ADDR_WIDTH'(NRES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_in_base;
    logic [ADDR_WIDTH-1:0] r_out_base;
    logic [PCW-1:0]        r_rd_cnt;
    logic [PCW-1:0]        r_rv_cnt;
    logic [ADDR_WIDTH-1:0] r_wr_cnt;
    logic                  r_req;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rd_pend;
    logic                  r_pix_valid;
    logic [DATA_WIDTH-1:0] r_pix_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_fifo [OFIFO_DEPTH];
    logic [FAW-1:0]        r_wptr;
    logic [FAW-1:0]        r_rptr;
    logic [FCW-1:0]        r_fcnt;

    logic w_active, w_empty, w_full, w_pop, w_push, w_rv, w_fin, w_idle_bus;

    assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_empty    = (r_fcnt == '0);
    assign w_full     = (r_fcnt == c_FDEPTH);
    assign w_pop      = r_req && r_we && mem_gnt_i;
    assign w_push     = res_valid_i && w_active && (!w_full || w_pop);
    assign w_rv       = r_rd_pend && mem_rvalid_i;
    assign w_fin      = (r_state == S_DRAIN) && !r_req && (r_wr_cnt >= c_NRES);
    // The bus is free only with nothing held and no read in flight; the final
    // DRAIN cycle must not launch a request that would outlive the frame.
    assign w_idle_bus = w_active && !r_req && !r_rd_pend && !w_fin;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= res_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_in_base   <= '0;
            r_out_base  <= '0;
            r_rd_cnt    <= '0;
            r_rv_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd_pend   <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fcnt      <= '0;
        end else begin
            r_pix_valid <= w_rv;
            if (w_rv) begin
                r_pix_data <= mem_rdata_i;
                r_rd_pend  <= 1'b0;
                r_rv_cnt   <= r_rv_cnt + PCW'(1);
            end

            if (w_push) r_wptr <= r_wptr + FAW'(1);
            if (w_pop)  r_rptr <= r_rptr + FAW'(1);
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + FCW'(1);
                2'b01:   r_fcnt <= r_fcnt - FCW'(1);
                default: r_fcnt <= r_fcnt;
            endcase
            if (res_valid_i && w_active && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end

            // Pending results always win the bus so the FIFO drains first.
            if (r_req && mem_gnt_i) begin
                r_req <= 1'b0;
                r_we  <= 1'b0;
                if (r_we) begin
                    r_wr_cnt <= r_wr_cnt + ADDR_WIDTH'(1);
                end else begin
                    r_rd_pend <= 1'b1;
                end
            end else if (w_idle_bus) begin
                if (!w_empty) begin
                    r_req   <= 1'b1;
                    r_we    <= 1'b1;
                    r_addr  <= r_out_base + r_wr_cnt;
                    r_wdata <= r_fifo[r_rptr];
                end else if ((r_rd_cnt != c_NPIX) && !w_full) begin
                    r_req    <= 1'b1;
                    r_we     <= 1'b0;
                    r_addr   <= r_in_base + ADDR_WIDTH'(r_rd_cnt);
                    r_rd_cnt <= r_rd_cnt + PCW'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_in_base  <= in_base_i;
                        r_out_base <= out_base_i;
                        r_rd_cnt   <= '0;
                        r_rv_cnt   <= '0;
                        r_wr_cnt   <= '0;
                        r_ovf      <= 1'b0;
                        r_wptr     <= '0;
                        r_rptr     <= '0;
                        r_fcnt     <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_rv && (r_rv_cnt == c_NPIX - PCW'(1))) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_fin) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign ovf_o       = r_ovf;
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign pix_valid_o = r_pix_valid;
    assign pix_data_o  = r_pix_data;

endmodule

`default_nettype wire

// File: tb/tb_cnn_frame_ctrl.sv
// tb_cnn_frame_ctrl: 4x4 frames against a memory responder, with a read/write/pixel
// scoreboard, a table of frame vectors and hand sequences for overflow and reset.
`default_nettype none

module tb_cnn_frame_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] in_base_i = '0;
    logic [31:0] out_base_i = '0;
    logic        busy_o, done_o, ovf_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [7:0]  mem_rdata_i = '0;
    logic        pix_valid_o;
    logic [7:0]  pix_data_o;
    logic        res_valid_i = 1'b0;
    logic [7:0]  res_data_i = '0;

    cnn_frame_ctrl #(
        .IMG_W(4), .IMG_H(4), .DATA_WIDTH(8), .ADDR_WIDTH(32), .OFIFO_DEPTH(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .in_base_i(in_base_i), .out_base_i(out_base_i),
        .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .pix_valid_o(pix_valid_o), .pix_data_o(pix_data_o),
        .res_valid_i(res_valid_i), .res_data_i(res_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] in_base;
        logic [31:0] out_base;
        int          gnt_delay;
        logic [7:0]  res;
        int          res_at;
        int          exp_npix;
        logic [31:0] exp_waddr;
        logic [7:0]  exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    vec_t        vecs[4];
    logic [31:0] exp_rd[$];
    wr_t         exp_wr[$];
    logic [7:0]  exp_pix[$];

    int n_checks = 0;
    int n_errors = 0;

    int          gnt_mode = 0;   // 0 none, 1 all, 2 reads only
    int          gnt_delay = 0;
    int          wait_cnt = 0;
    bit          rv_next = 0;
    bit          rd_out = 0;
    logic [7:0]  rv_data = '0;
    logic [31:0] h_addr = '0;
    logic        h_we = 1'b0;
    logic [7:0]  h_wdata = '0;
    int          rd_grants = 0;
    int          wr_grants = 0;
    int          pix_cnt = 0;
    int          inj_rd = 0;
    bit          inj_valid = 0;
    logic [31:0] cur_in_base = '0;

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Memory responder and output monitor.
    always @(negedge clk_i) begin
        logic [31:0] e;
        wr_t         w;
        logic [7:0]  p;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        if (!rst_ni) begin
            rv_next  = 0;
            rd_out   = 0;
            wait_cnt = 0;
        end else begin
            if (rd_out) chk("one_outstanding", !mem_req_o, longint'(mem_req_o), 0);
            if (rv_next) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rv_data;
                exp_pix.push_back(rv_data);
                rv_next = 0;
                rd_out  = 0;
            end
            if (mem_req_o) begin
                if (wait_cnt > 0)
                    chk("hold_stable", {mem_addr_o, mem_we_o, mem_wdata_o} == {h_addr, h_we, h_wdata},
                        longint'({mem_addr_o, mem_we_o, mem_wdata_o}), longint'({h_addr, h_we, h_wdata}));
                else begin
                    h_addr = mem_addr_o; h_we = mem_we_o; h_wdata = mem_wdata_o;
                end
                if ((gnt_mode == 1 || (gnt_mode == 2 && !mem_we_o)) && wait_cnt >= gnt_delay) begin
                    mem_gnt_i = 1'b1;
                    wait_cnt  = 0;
                    if (!mem_we_o) begin
                        rd_grants++;
                        if (exp_rd.size() == 0) chk("read_unexpected", 0, longint'(mem_addr_o), 0);
                        else begin
                            e = exp_rd.pop_front();
                            chk("read_addr", mem_addr_o == e, longint'(mem_addr_o), longint'(e));
                        end
                        rv_data = 8'(mem_addr_o - cur_in_base);
                        rv_next = 1;
                        rd_out  = 1;
                    end else begin
                        wr_grants++;
                        if (inj_valid)
                            chk("write_before_read", rd_grants <= inj_rd + 1, longint'(rd_grants), longint'(inj_rd + 1));
                        if (exp_wr.size() == 0) chk("write_unexpected", 0, longint'({mem_addr_o, mem_wdata_o}), 0);
                        else begin
                            w = exp_wr.pop_front();
                            chk("write_addr_data", {mem_addr_o, mem_wdata_o} == {w.a, w.d},
                                longint'({mem_addr_o, mem_wdata_o}), longint'({w.a, w.d}));
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            if (pix_valid_o) begin
                pix_cnt++;
                if (exp_pix.size() == 0) chk("pix_unexpected", 0, longint'(pix_data_o), 0);
                else begin
                    p = exp_pix.pop_front();
                    chk("pix_data", pix_data_o == p, longint'(pix_data_o), longint'(p));
                end
            end
        end
    end

    task automatic run_frame(input vec_t v);
        bit injected;
        bit finished;
        exp_rd.delete();
        for (int k = 0; k < 16; k++) exp_rd.push_back(v.in_base + 32'(k));
        cur_in_base = v.in_base;
        gnt_delay   = v.gnt_delay;
        gnt_mode    = 1;
        pix_cnt     = 0;
        wr_grants   = 0;
        rd_grants   = 0;
        inj_valid   = 0;
        @(negedge clk_i);
        in_base_i  = v.in_base;
        out_base_i = v.out_base;
        start_i    = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("busy_after_start", busy_o == 1'b1, longint'(busy_o), 1);
        injected = 0;
        finished = 0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            @(negedge clk_i);
            res_valid_i = 1'b0;
            if (done_o) begin
                finished = 1;
                chk("busy_low_at_done", busy_o == 1'b0, longint'(busy_o), 0);
            end else if (!injected && pix_cnt >= v.res_at) begin
                res_valid_i = 1'b1;
                res_data_i  = v.res;
                exp_wr.push_back(wr_t'{v.exp_waddr, v.exp_wdata});
                inj_rd    = rd_grants;
                inj_valid = 1;
                injected  = 1;
            end
        end
        res_valid_i = 1'b0;
        chk("done_seen", finished, longint'(finished), 1);
        @(negedge clk_i);
        chk("done_one_cycle", {done_o, busy_o} == 2'b00, longint'({done_o, busy_o}), 0);
        chk("pix_count", pix_cnt == v.exp_npix, longint'(pix_cnt), longint'(v.exp_npix));
        chk("write_count", wr_grants == 1, longint'(wr_grants), 1);
        chk("queues_empty", exp_rd.size() + exp_wr.size() + exp_pix.size() == 0,
            longint'(exp_rd.size() + exp_wr.size() + exp_pix.size()), 0);
        chk("ovf_clear", ovf_o == 1'b0, longint'(ovf_o), 0);
    endtask

    function automatic longint all_outs();
        return longint'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, pix_valid_o,
                         pix_data_o, busy_o, done_o, ovf_o});
    endfunction

    initial begin
        bit found;
        vecs[0] = '{32'h0000_0100, 32'h0000_0800, 0, 8'h5A, 16, 16, 32'h0000_0800, 8'h5A};
        vecs[1] = '{32'h0000_0100, 32'h0000_0900, 3, 8'h33, 5,  16, 32'h0000_0900, 8'h33};
        vecs[2] = '{32'hFFFF_FFFA, 32'hFFFF_FFFF, 1, 8'hC3, 0,  16, 32'hFFFF_FFFF, 8'hC3};
        vecs[3] = '{32'h0000_0040, 32'h0000_0000, 2, 8'h01, 10, 16, 32'h0000_0000, 8'h01};

        repeat (3) @(negedge clk_i);
        chk("reset_state", all_outs() == 0, all_outs(), 0);
        rst_ni = 1'b1;

        // A result in IDLE must not reach the FIFO; frame 0 would see it as a stray write.
        @(negedge clk_i);
        res_valid_i = 1'b1;
        res_data_i  = 8'hEE;
        @(negedge clk_i);
        res_valid_i = 1'b0;
        chk("idle_no_req", mem_req_o == 1'b0, longint'(mem_req_o), 0);

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Overflow with grants withheld, then reset while the write is held.
        exp_rd.delete();
        exp_rd.push_back(32'h200);
        cur_in_base = 32'h200;
        gnt_mode    = 0;
        gnt_delay   = 0;
        inj_valid   = 0;
        pix_cnt     = 0;
        @(negedge clk_i);
        in_base_i  = 32'h200;
        out_base_i = 32'h300;
        start_i    = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("held_read", {mem_req_o, mem_we_o, mem_addr_o} == {1'b1, 1'b0, 32'h200},
            longint'({mem_req_o, mem_we_o, mem_addr_o}), longint'({1'b1, 1'b0, 32'h200}));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (i == 4) chk("no_ovf_at_full", ovf_o == 1'b0, longint'(ovf_o), 0);
            res_valid_i = 1'b1;
            res_data_i  = 8'hA0 + 8'(i);
        end
        @(negedge clk_i);
        res_valid_i = 1'b0;
        chk("ovf_set", ovf_o == 1'b1, longint'(ovf_o), 1);
        gnt_mode = 2;
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk_i);
            found = mem_req_o && mem_we_o;
        end
        chk("write_after_full", found, longint'(found), 1);
        chk("first_write_order", {mem_addr_o, mem_wdata_o} == {32'h300, 8'hA0},
            longint'({mem_addr_o, mem_wdata_o}), longint'({32'h300, 8'hA0}));
        chk("pix_before_write", pix_cnt == 1, longint'(pix_cnt), 1);
        chk("ovf_sticky", ovf_o == 1'b1, longint'(ovf_o), 1);

        rst_ni = 1'b0;
        #1;
        chk("reset_midframe", all_outs() == 0, all_outs(), 0);
        exp_rd.delete();
        exp_wr.delete();
        exp_pix.delete();
        inj_valid = 0;
        repeat (2) @(negedge clk_i);
        rst_ni   = 1'b1;
        gnt_mode = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            chk("no_req_before_start", mem_req_o == 1'b0, longint'(mem_req_o), 0);
        end
        run_frame(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/cnn_frame_ctrl.md
CNN_FRAME_CTRL -- requirements
Module: cnn_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 28, input image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, input image height in pixels.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, pixel/result width; ADDR_WIDTH, default 32, address width; OFIFO_DEPTH, default 4, result FIFO entries (power of 2).
REQ-004 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: start_i  in  1  start pulse; in_base_i  in  ADDR_WIDTH  image base; out_base_i  in  ADDR_WIDTH  result base.
REQ-006 SHALL have ports: busy_o  out  1  frame in progress; done_o  out  1  one-cycle completion pulse; ovf_o  out  1  sticky result-drop flag.
REQ-007 SHALL have ports: mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  ADDR_WIDTH; mem_wdata_o  out  DATA_WIDTH; mem_gnt_i  in  1; mem_rvalid_i  in  1; mem_rdata_i  in  DATA_WIDTH.
REQ-008 SHALL have ports: pix_valid_o  out  1, pix_data_o  out  DATA_WIDTH (pixel stream to line buffer); res_valid_i  in  1, res_data_i  in  DATA_WIDTH (pooled results).

Function
REQ-009 SHALL implement states IDLE, RUN, DRAIN, FINISH.
REQ-010 IDLE: start_i=1 SHALL latch in_base_i/out_base_i, clear pixel/result counters and ovf_o, go to RUN next cycle; start_i outside IDLE SHALL be ignored.
REQ-011 busy_o SHALL be 1 in RUN and DRAIN only.
REQ-012 Memory request SHALL be held (mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o stable) until the cycle mem_gnt_i=1; transfer completes on that cycle.
REQ-013 At most one read SHALL be outstanding; after a read grant no new request until mem_rvalid_i=1 (rvalid arrives >=1 cycle after grant).
REQ-014 Write completes on grant; no rvalid expected for writes.
REQ-015 Arbitration when no request held: write if result FIFO non-empty, else read if pixels remain and FIFO not full, else no request.
REQ-016 Read k (k=0..IMG_W*IMG_H-1) SHALL use address in_base+k, mem_we_o=0.
REQ-017 Write j SHALL use address out_base+j, mem_we_o=1, mem_wdata_o = FIFO head; head popped on grant.
REQ-018 On mem_rvalid_i for an outstanding read, pix_valid_o SHALL be 1 and pix_data_o = mem_rdata_i registered, exactly one cycle later, for one cycle.
REQ-019 res_valid_i=1 SHALL push res_data_i into FIFO; if full and no pop that cycle, result dropped, ovf_o set; simultaneous push+pop when full SHALL succeed.
REQ-020 Expected result count SHALL be NRES=((IMG_W-2)/2)*((IMG_H-2)/2) (169 at defaults).
REQ-021 RUN->DRAIN when all IMG_W*IMG_H pixels' rvalid received; DRAIN->FINISH when NRES writes granted and no request held.
REQ-022 FINISH SHALL assert done_o for exactly one cycle and return to IDLE next cycle.
REQ-023 Results arriving in IDLE/FINISH SHALL be ignored.
REQ-024 Counters SHALL saturate-free wrap only at their terminal values; addresses wrap modulo 2^ADDR_WIDTH.

Reset
REQ-025 rst_ni low SHALL immediately force IDLE, empty FIFO, counters 0, and all outputs 0 (mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, pix_valid_o, pix_data_o, busy_o, done_o, ovf_o), including mid-frame with a request pending.
REQ-026 After reset release, no memory request SHALL issue before start_i.

Verification
REQ-027 IMG_W=IMG_H=4, in_base=0x100, start, mem grants immediate, rvalid 1 cycle later, ramp data -> reads 0x100..0x10F in order, 16 pix_valid pulses with data 0..15.
REQ-028 Same, datapath returns 1 result (NRES=1) value 0x5A -> one write addr out_base+0, wdata 0x5A, then done_o one cycle, busy_o falls.
REQ-029 Grant delayed 3 cycles -> mem_addr_o/mem_we_o stable for all 4 cycles; no second request.
REQ-030 Result arrives with read pending in FIFO -> write issued before next read; results written in arrival order.
REQ-031 OFIFO_DEPTH=4, grants withheld, 6 results pushed -> 4 kept, ovf_o=1, reads blocked while full.
REQ-032 rst_ni asserted mid-RUN with request held -> all outputs 0 same cycle; new start restarts at in_base+0.
